// File: rtl/exc_controller_if.sv
// Exception sideband bundle between the LEGv8 datapath/decoder and the exception controller.
// master = controller side (drives Exc/EStatus/status), slave = core/datapath side.
interface exc_controller_if #(
  parameter int unsigned NSRC = 4
);
  logic [NSRC-1:0] irq_req;
  logic [NSRC-1:0] irq_mask;
  logic            invalid_op;
  logic            ERet;
  logic            ExcAck;
  logic            Exc;
  logic [3:0]      EStatus;
  logic            in_handler;
  logic [NSRC-1:0] pending;
  logic            ack_err;
  logic            double_fault;

  modport master (
    input  irq_req, irq_mask, invalid_op, ERet, ExcAck,
    output Exc, EStatus, in_handler, pending, ack_err, double_fault
  );

  modport slave (
    output irq_req, irq_mask, invalid_op, ERet, ExcAck,
    input  Exc, EStatus, in_handler, pending, ack_err, double_fault
  );
endinterface

// File: rtl/exc_controller.sv
// Exception sequencer: latches IRQ edges and invalid-opcode flags, raises one prioritised
// request to the datapath, waits for ExcAck, and blocks further exceptions until ERET.
module exc_controller #(
  parameter int unsigned NSRC        = 4,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  exc_controller_if.master   bus
);

  localparam int unsigned TW = 8;
  localparam int unsigned IW = 3;

  localparam logic [3:0] CAUSE_INVALID_OP = 4'b0010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HANDLER
  } state_e;

  state_e          state_q, state_d;
  logic [NSRC-1:0] irq_prev_q;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] irq_rise;
  logic [NSRC-1:0] pend_clr;
  logic [NSRC-1:0] eligible;
  logic [TW-1:0]   timer_q, timer_d;
  logic [IW-1:0]   grant_idx_q, grant_idx_d;
  logic            grant_irq_q, grant_irq_d;
  logic            exc_q, exc_d;
  logic [3:0]      estatus_q, estatus_d;
  logic            in_handler_q, in_handler_d;
  logic            ack_err_q, ack_err_d;
  logic            double_fault_q, double_fault_d;
  logic [IW-1:0]   low_idx;
  logic            low_valid;

  assign irq_rise = bus.irq_req & ~irq_prev_q;
  assign eligible = pend_q & ~bus.irq_mask;

  // Fixed priority: the lowest eligible index wins, so scan from the top down.
  always_comb begin
    low_idx   = '0;
    low_valid = 1'b0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        low_idx   = IW'(i);
        low_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    grant_idx_d    = grant_idx_q;
    grant_irq_d    = grant_irq_q;
    exc_d          = exc_q;
    estatus_d      = estatus_q;
    in_handler_d   = in_handler_q;
    ack_err_d      = ack_err_q;
    double_fault_d = double_fault_q;
    pend_clr       = '0;

    case (state_q)
      S_IDLE: begin
        exc_d = 1'b0;
        if (bus.invalid_op) begin
          state_d     = S_REQ;
          exc_d       = 1'b1;
          estatus_d   = CAUSE_INVALID_OP;
          grant_irq_d = 1'b0;
          timer_d     = '0;
        end else if (low_valid) begin
          state_d     = S_REQ;
          exc_d       = 1'b1;
          estatus_d   = {1'b1, low_idx};
          grant_idx_d = low_idx;
          grant_irq_d = 1'b1;
          timer_d     = '0;
        end
      end

      S_REQ: begin
        if (bus.ExcAck) begin
          state_d      = S_HANDLER;
          exc_d        = 1'b0;
          in_handler_d = 1'b1;
          if (grant_irq_q) begin
            pend_clr = NSRC'(1) << grant_idx_q;
          end
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          // Abandon the request; an IRQ stays pending and is re-arbitrated from IDLE.
          state_d   = S_IDLE;
          exc_d     = 1'b0;
          ack_err_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_HANDLER: begin
        exc_d = 1'b0;
        if (bus.invalid_op) begin
          double_fault_d = 1'b1;
        end
        if (bus.ERet) begin
          state_d      = S_IDLE;
          in_handler_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        exc_d   = 1'b0;
      end
    endcase

    // A new edge on the bit being cleared wins over the clear.
    pend_d = (pend_q & ~pend_clr) | irq_rise;
  end

  always_ff @(posedge clk) begin
    irq_prev_q <= bus.irq_req;
    if (reset) begin
      state_q        <= S_IDLE;
      pend_q         <= '0;
      timer_q        <= '0;
      grant_idx_q    <= '0;
      grant_irq_q    <= 1'b0;
      exc_q          <= 1'b0;
      estatus_q      <= 4'b0000;
      in_handler_q   <= 1'b0;
      ack_err_q      <= 1'b0;
      double_fault_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_q         <= pend_d;
      timer_q        <= timer_d;
      grant_idx_q    <= grant_idx_d;
      grant_irq_q    <= grant_irq_d;
      exc_q          <= exc_d;
      estatus_q      <= estatus_d;
      in_handler_q   <= in_handler_d;
      ack_err_q      <= ack_err_d;
      double_fault_q <= double_fault_d;
    end
  end

  assign bus.Exc          = exc_q;
  assign bus.EStatus      = estatus_q;
  assign bus.in_handler   = in_handler_q;
  assign bus.pending      = pend_q;
  assign bus.ack_err      = ack_err_q;
  assign bus.double_fault = double_fault_q;

endmodule

// File: tb/tb_exc_controller.sv
// Bench for exc_controller: directed vector table, hand-written corner sequences,
// then randomized traffic against a behavioural model of the exception rules.
module tb_exc_controller;

  localparam int unsigned NSRC        = 4;
  localparam int unsigned ACK_TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exc_controller_if #(.NSRC(NSRC)) bus ();

  exc_controller #(.NSRC(NSRC), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: a request is outstanding, a handler is running, or neither.
  logic [3:0] m_prev, m_pend, m_est;
  bit         m_req_out, m_inh, m_ackerr, m_df;
  int         m_waited;
  int         m_gidx;

  task automatic model_step(input logic [3:0] irq, input logic [3:0] mask, input logic inv,
                            input logic eret, input logic ack, input logic rst);
    logic [3:0] rise, clr, elig;
    int         lo;
    if (rst) begin
      m_prev = irq; m_pend = '0; m_est = '0; m_req_out = 0; m_inh = 0;
      m_ackerr = 0; m_df = 0; m_waited = 0; m_gidx = -1;
      return;
    end
    rise = irq & ~m_prev;
    clr  = '0;
    elig = m_pend & ~mask;
    if (m_req_out) begin
      if (ack) begin
        m_req_out = 0;
        m_inh     = 1;
        if (m_gidx >= 0) clr[m_gidx] = 1'b1;
      end else begin
        m_waited++;
        if (m_waited >= int'(ACK_TIMEOUT)) begin
          m_req_out = 0;
          m_ackerr  = 1;
        end
      end
    end else if (m_inh) begin
      if (inv)  m_df  = 1;
      if (eret) m_inh = 0;
    end else if (inv) begin
      m_req_out = 1; m_est = 4'b0010; m_gidx = -1; m_waited = 0;
    end else if (elig != 0) begin
      lo = -1;
      for (int i = 0; i < int'(NSRC); i++) if (elig[i] && lo < 0) lo = i;
      m_req_out = 1; m_est = 4'b1000 + 4'(lo); m_gidx = lo; m_waited = 0;
    end
    m_pend = (m_pend & ~clr) | rise;
    m_prev = irq;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs, advance one clock, update the model, sample 1 time unit after the edge.
  task automatic step(input logic [3:0] irq, input logic [3:0] mask, input logic inv,
                      input logic eret, input logic ack);
    bus.irq_req    = irq;
    bus.irq_mask   = mask;
    bus.invalid_op = inv;
    bus.ERet       = eret;
    bus.ExcAck     = ack;
    @(posedge clk);
    model_step(irq, mask, inv, eret, ack, reset);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] irq);
    reset = 1'b1;
    repeat (2) step(irq, 4'b0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_exc"},  8'(bus.Exc),          8'(m_req_out));
    check({tag, "_est"},  8'(bus.EStatus),      8'(m_est));
    check({tag, "_inh"},  8'(bus.in_handler),   8'(m_inh));
    check({tag, "_pend"}, 8'(bus.pending),      8'(m_pend));
    check({tag, "_aerr"}, 8'(bus.ack_err),      8'(m_ackerr));
    check({tag, "_df"},   8'(bus.double_fault), 8'(m_df));
  endtask

  typedef struct {
    logic [3:0] irq;
    logic [3:0] mask;
    logic       inv, eret, ack;
    logic       exc;
    logic [3:0] est;
    logic       inh;
    logic [3:0] pend;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] irq, input logic [3:0] mask, input logic inv,
                              input logic eret, input logic ack, input logic exc,
                              input logic [3:0] est, input logic inh, input logic [3:0] pend);
    vec_t v;
    v.irq = irq; v.mask = mask; v.inv = inv; v.eret = eret; v.ack = ack;
    v.exc = exc; v.est = est; v.inh = inh; v.pend = pend;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int hi;
    logic [3:0] r_irq, r_mask;
    logic r_inv, r_eret, r_ack;

    reset = 1'b1;
    bus.irq_req = '0; bus.irq_mask = '0; bus.invalid_op = 0; bus.ERet = 0; bus.ExcAck = 0;

    // irq, mask, inv, eret, ack  ->  Exc, EStatus, in_handler, pending
    tbl.push_back(mk(4'b0100, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 4'b0100));
    tbl.push_back(mk(4'b0100, 4'b0000, 0, 0, 0, 1, 4'b1010, 0, 4'b0100));
    tbl.push_back(mk(4'b0100, 4'b0000, 0, 0, 1, 0, 4'b1010, 1, 4'b0000));
    tbl.push_back(mk(4'b0100, 4'b0000, 0, 1, 0, 0, 4'b1010, 0, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b1010, 0, 4'b0000));
    tbl.push_back(mk(4'b0001, 4'b0000, 1, 0, 0, 1, 4'b0010, 0, 4'b0001));
    tbl.push_back(mk(4'b0001, 4'b0000, 0, 0, 0, 1, 4'b0010, 0, 4'b0001));
    tbl.push_back(mk(4'b0001, 4'b0000, 0, 0, 1, 0, 4'b0010, 1, 4'b0001));
    tbl.push_back(mk(4'b0001, 4'b0000, 0, 1, 0, 0, 4'b0010, 0, 4'b0001));
    tbl.push_back(mk(4'b0001, 4'b0000, 0, 0, 0, 1, 4'b1000, 0, 4'b0001));
    tbl.push_back(mk(4'b0001, 4'b0000, 0, 0, 1, 0, 4'b1000, 1, 4'b0000));
    tbl.push_back(mk(4'b0001, 4'b0000, 0, 1, 0, 0, 4'b1000, 0, 4'b0000));
    tbl.push_back(mk(4'b1011, 4'b0000, 0, 0, 0, 0, 4'b1000, 0, 4'b1010));
    tbl.push_back(mk(4'b1011, 4'b0000, 0, 0, 0, 1, 4'b1001, 0, 4'b1010));
    tbl.push_back(mk(4'b1011, 4'b0000, 0, 0, 1, 0, 4'b1001, 1, 4'b1000));
    tbl.push_back(mk(4'b1011, 4'b0000, 0, 1, 0, 0, 4'b1001, 0, 4'b1000));
    tbl.push_back(mk(4'b1011, 4'b0000, 0, 0, 0, 1, 4'b1011, 0, 4'b1000));
    tbl.push_back(mk(4'b1011, 4'b0000, 0, 0, 1, 0, 4'b1011, 1, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 1, 0, 0, 4'b1011, 0, 4'b0000));
    tbl.push_back(mk(4'b1010, 4'b0010, 0, 0, 0, 0, 4'b1011, 0, 4'b1010));
    tbl.push_back(mk(4'b1010, 4'b0010, 0, 0, 0, 1, 4'b1011, 0, 4'b1010));
    tbl.push_back(mk(4'b1010, 4'b0010, 0, 0, 1, 0, 4'b1011, 1, 4'b0010));
    tbl.push_back(mk(4'b1010, 4'b0010, 0, 1, 0, 0, 4'b1011, 0, 4'b0010));
    tbl.push_back(mk(4'b1010, 4'b0010, 0, 0, 0, 0, 4'b1011, 0, 4'b0010));
    tbl.push_back(mk(4'b1010, 4'b0010, 0, 0, 0, 0, 4'b1011, 0, 4'b0010));

    // Line held high through reset is not an edge.
    do_reset(4'b0001);
    check("rst_exc",  8'(bus.Exc),          8'd0);
    check("rst_est",  8'(bus.EStatus),      8'd0);
    check("rst_inh",  8'(bus.in_handler),   8'd0);
    check("rst_aerr", 8'(bus.ack_err),      8'd0);
    check("rst_df",   8'(bus.double_fault), 8'd0);
    for (int i = 0; i < 10; i++) begin
      step(4'b0001, 4'b0000, 0, 0, 0);
      check($sformatf("hold_pend%0d", i), 8'(bus.pending), 8'd0);
      check($sformatf("hold_exc%0d", i),  8'(bus.Exc),     8'd0);
    end

    do_reset(4'b0000);
    foreach (tbl[k]) begin
      step(tbl[k].irq, tbl[k].mask, tbl[k].inv, tbl[k].eret, tbl[k].ack);
      check($sformatf("tbl%0d_exc", k),  8'(bus.Exc),        8'(tbl[k].exc));
      check($sformatf("tbl%0d_est", k),  8'(bus.EStatus),    8'(tbl[k].est));
      check($sformatf("tbl%0d_inh", k),  8'(bus.in_handler), 8'(tbl[k].inh));
      check($sformatf("tbl%0d_pend", k), 8'(bus.pending),    8'(tbl[k].pend));
    end

    // Ack timeout: Exc held exactly ACK_TIMEOUT cycles, then re-raised one cycle later.
    do_reset(4'b0000);
    step(4'b0001, 4'b0000, 0, 0, 0);
    check("to_pend0", 8'(bus.pending), 8'b0001);
    step(4'b0001, 4'b0000, 0, 0, 0);
    check("to_exc_rise", 8'(bus.Exc), 8'd1);
    hi = 0;
    while (bus.Exc === 1'b1 && hi < 40) begin
      hi++;
      step(4'b0001, 4'b0000, 0, 0, 0);
    end
    check("to_hi_cycles", 8'(hi), 8'(ACK_TIMEOUT));
    check("to_exc_low",   8'(bus.Exc),     8'd0);
    check("to_aerr",      8'(bus.ack_err), 8'd1);
    check("to_pend1",     8'(bus.pending), 8'b0001);
    step(4'b0001, 4'b0000, 0, 0, 0);
    check("to_reexc", 8'(bus.Exc),     8'd1);
    check("to_reest", 8'(bus.EStatus), 8'b1000);

    // Invalid opcode inside the handler, then reset mid-handler.
    step(4'b0001, 4'b0000, 0, 0, 1);
    check("df_inh", 8'(bus.in_handler), 8'd1);
    step(4'b0001, 4'b0000, 1, 0, 0);
    check("df_flag", 8'(bus.double_fault), 8'd1);
    check("df_exc",  8'(bus.Exc),          8'd0);
    step(4'b0001, 4'b0000, 0, 0, 0);
    check("df_exc2", 8'(bus.Exc), 8'd0);
    reset = 1'b1;
    step(4'b0001, 4'b0000, 0, 0, 0);
    reset = 1'b0;
    check("mrst_exc",  8'(bus.Exc),          8'd0);
    check("mrst_est",  8'(bus.EStatus),      8'd0);
    check("mrst_inh",  8'(bus.in_handler),   8'd0);
    check("mrst_pend", 8'(bus.pending),      8'd0);
    check("mrst_aerr", 8'(bus.ack_err),      8'd0);
    check("mrst_df",   8'(bus.double_fault), 8'd0);

    // Randomized traffic against the model; slow-ack phases provoke timeouts.
    do_reset(4'b0000);
    r_irq = '0; r_mask = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) r_irq = r_irq ^ (4'($urandom) & 4'($urandom));
      if ($urandom_range(0, 15) == 0) r_mask = 4'($urandom) & 4'($urandom);
      r_inv  = ($urandom_range(0, 7) == 0);
      r_eret = ($urandom_range(0, 4) == 0);
      r_ack  = ((c / 500) % 2 == 1) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) == 0);
      reset  = ($urandom_range(0, 299) == 0);
      step(r_irq, r_mask, r_inv, r_eret, r_ack);
      reset  = 1'b0;
      check_model($sformatf("rnd%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
